// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer/arbiter: opcode constants, FSM states,
// default datapath width and the local signed-overflow helper.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] OP_MOVE   = 4'd0;
    localparam logic [3:0] OP_NOT    = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_SUB    = 4'd3;
    localparam logic [3:0] OP_OR     = 4'd4;
    localparam logic [3:0] OP_AND    = 4'd5;
    localparam logic [3:0] OP_XOR    = 4'd6;
    localparam logic [3:0] OP_SLT    = 4'd7;
    localparam logic [3:0] OP_SLTU   = 4'd8;
    localparam logic [3:0] OP_PACKHI = 4'd9;
    localparam logic [3:0] OP_PACKLO = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The external ALU does not export overflow, so it is rebuilt from the sign bits.
    function automatic logic calc_ovf(input logic [3:0] op, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
        logic ovf;
        case (op)
            OP_ADD:  ovf = (a_msb == b_msb) && (r_msb != a_msb);
            OP_SUB:  ovf = (a_msb != b_msb) && (r_msb != a_msb);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

endpackage

// File: rtl/alu_rr_grant.sv
// Combinational two-way grant: one-hot grant plus granted ID from the two valids and
// the preferred-requester pointer. ALU_ARB_FIXED_PRIO_EN selects fixed priority to 0.
module alu_rr_grant (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Pick a single winner; a lone requester wins regardless of the pointer.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (valid0) begin
            grant    = 2'b01;
            grant_id = 1'b0;
        end else if (valid1) begin
            grant    = 2'b10;
            grant_id = 1'b1;
        end else begin
            grant    = 2'b00;
            grant_id = 1'b0;
        end
`else
        if (valid0 && valid1) begin
            grant    = ptr ? 2'b10 : 2'b01;
            grant_id = ptr;
        end else if (valid0) begin
            grant    = 2'b01;
            grant_id = 1'b0;
        end else if (valid1) begin
            grant    = 2'b10;
            grant_id = 1'b1;
        end else begin
            grant    = 2'b00;
            grant_id = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/alu_arbiter.sv
// Sequencer/arbiter sharing one external combinational ALU between two requesters.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority to requester 0, no pointer).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovf,
    output logic             busy
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             ptr_s;
    logic [1:0]       grant_s;
    logic             grant_id_s;
    logic             accept_s;
    logic             done_s;
    logic             id_r;
    logic [3:0]       alu_opcode_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_ovf_r;
    logic             busy_r;

    alu_rr_grant u_grant (
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .ptr      (ptr_s),
        .grant    (grant_s),
        .grant_id (grant_id_s)
    );

    assign accept_s   = (state_r == ST_IDLE) && (grant_s != 2'b00);
    assign done_s     = (state_r == ST_RESP) && rsp_valid_r && rsp_ready;
    assign req0_ready = (state_r == ST_IDLE) && grant_s[0];
    assign req1_ready = (state_r == ST_IDLE) && grant_s[1];

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operand capture at acceptance; held untouched until the next acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_opcode_r <= 4'd0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            id_r         <= 1'b0;
        end else if (accept_s) begin
            alu_opcode_r <= grant_id_s ? req1_op : req0_op;
            alu_a_r      <= grant_id_s ? req1_a  : req0_a;
            alu_b_r      <= grant_id_s ? req1_b  : req0_b;
            id_r         <= grant_id_s;
        end else begin
            alu_opcode_r <= alu_opcode_r;
            alu_a_r      <= alu_a_r;
            alu_b_r      <= alu_b_r;
            id_r         <= id_r;
        end
    end

    // Response capture in EXEC, release on the response handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_result_r <= '0;
            rsp_ovf_r    <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= id_r;
            rsp_result_r <= alu_result;
            rsp_ovf_r    <= calc_ovf(alu_opcode_r, alu_a_r[WIDTH-1], alu_b_r[WIDTH-1],
                                     alu_result[WIDTH-1]);
        end else if (done_s) begin
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= rsp_id_r;
            rsp_result_r <= rsp_result_r;
            rsp_ovf_r    <= rsp_ovf_r;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
            rsp_id_r     <= rsp_id_r;
            rsp_result_r <= rsp_result_r;
            rsp_ovf_r    <= rsp_ovf_r;
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign ptr_s = 1'b0;
`else
    logic ptr_r;

    // Round-robin pointer: after a completed response, prefer the other requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= 1'b0;
        end else if (done_s) begin
            ptr_r <= ~rsp_id_r;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`endif

    assign alu_opcode = alu_opcode_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_ovf    = rsp_ovf_r;
    assign busy       = busy_r;

endmodule
